// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the Game of Life engine.
package life_pkg;

  localparam int unsigned GRID_SIZE_DEFAULT = 20;

  // Coordinate width; never narrower than one bit.
  function automatic int unsigned cw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CW_DEFAULT = cw_of(GRID_SIZE_DEFAULT);

  typedef enum logic [1:0] {IDLE, COMPUTE, WAIT_VB, SWAP} life_state_t;

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 next-state rule for a single cell given its eight neighbours.
module life_cell_rule (
  input  logic       i_cur,
  input  logic [7:0] i_nbr,
  output logic       o_next
);

  logic [3:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      w_cnt = w_cnt + {3'b000, i_nbr[i]};
    end
  end

  assign o_next = (w_cnt == 4'd3) | (i_cur & (w_cnt == 4'd2));

endmodule

// File: rtl/life_engine.sv
// Double-buffered toroidal Game of Life store; one cell per cycle is computed into the back
// buffer and the result is swapped into the front buffer at the start of vertical blanking.
module life_engine
  import life_pkg::*;
#(
  parameter int unsigned GRID_SIZE   = GRID_SIZE_DEFAULT,
  parameter int unsigned STEP_FRAMES = 30,
  localparam int unsigned CW         = cw_of(GRID_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vblank_n,
  input  logic          i_run,
  input  logic          i_step,
  input  logic          i_clear,
  input  logic          i_wr_en,
  input  logic [CW-1:0] i_wr_row,
  input  logic [CW-1:0] i_wr_col,
  input  logic          i_wr_data,
  input  logic [CW-1:0] i_rd_row,
  input  logic [CW-1:0] i_rd_col,
  output logic          o_rd_cell,
  output logic          o_busy,
  output logic [15:0]   o_generation
);

  localparam int unsigned   FW         = cw_of(STEP_FRAMES);
  localparam logic [CW-1:0] LAST       = CW'(GRID_SIZE - 1);
  localparam logic [CW:0]   GRID_LIM   = (CW + 1)'(GRID_SIZE);
  localparam logic [FW-1:0] FRAME_LAST = FW'(STEP_FRAMES - 1);

  life_state_t r_state, w_state_next;

  logic [GRID_SIZE-1:0][GRID_SIZE-1:0] r_front, r_back;
  logic [CW-1:0] r_row, r_col;
  logic [FW-1:0] r_frame;
  logic [15:0]   r_gen;
  logic          r_pending, r_vb_prev, r_rd_cell;

  logic          w_vb_start, w_step_req, w_wr_ok, w_rd_ok, w_start, w_last_cell, w_next;
  logic [CW-1:0] w_rm, w_rp, w_cm, w_cp;
  logic [7:0]    w_nbr;

  function automatic logic in_range(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return ({1'b0, r} < GRID_LIM) && ({1'b0, c} < GRID_LIM);
  endfunction

  assign w_vb_start  = r_vb_prev & ~i_vblank_n;
  assign w_step_req  = i_run & w_vb_start & (r_frame == FRAME_LAST);
  assign w_wr_ok     = i_wr_en & in_range(i_wr_row, i_wr_col);
  assign w_rd_ok     = in_range(i_rd_row, i_rd_col);
  assign w_start     = (r_state == IDLE) & ~i_clear & ~w_wr_ok & r_pending;
  assign w_last_cell = (r_row == LAST) && (r_col == LAST);

  // Toroidal neighbour coordinates around the current compute index.
  assign w_rm = (r_row == '0)  ? LAST : r_row - 1'b1;
  assign w_rp = (r_row == LAST) ? '0  : r_row + 1'b1;
  assign w_cm = (r_col == '0)  ? LAST : r_col - 1'b1;
  assign w_cp = (r_col == LAST) ? '0  : r_col + 1'b1;

  assign w_nbr = {r_front[w_rm][w_cm], r_front[w_rm][r_col], r_front[w_rm][w_cp],
                  r_front[r_row][w_cm],                      r_front[r_row][w_cp],
                  r_front[w_rp][w_cm], r_front[w_rp][r_col], r_front[w_rp][w_cp]};

  life_cell_rule u_rule (
    .i_cur  (r_front[r_row][r_col]),
    .i_nbr  (w_nbr),
    .o_next (w_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start)     w_state_next = COMPUTE;
      COMPUTE: if (w_last_cell) w_state_next = WAIT_VB;
      WAIT_VB: if (w_vb_start)  w_state_next = SWAP;
      SWAP:                     w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front <= '0;
      r_back  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_gen   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_clear) begin
            r_front <= '0;
            r_back  <= '0;
          end else if (w_wr_ok) begin
            r_front[i_wr_row][i_wr_col] <= i_wr_data;
          end else if (r_pending) begin
            r_row <= '0;
            r_col <= '0;
          end
        end
        COMPUTE: begin
          r_back[r_row][r_col] <= w_next;
          if (r_col == LAST) begin
            r_col <= '0;
            r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        SWAP: begin
          r_front <= r_back;
          r_gen   <= r_gen + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Requests are only captured in IDLE; anything arriving while busy is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if ((r_state == IDLE) && (i_step || w_step_req)) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame <= '0;
    end else if (!i_run) begin
      r_frame <= '0;
    end else if (w_vb_start) begin
      r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vb_prev <= 1'b0;
      r_rd_cell <= 1'b0;
    end else begin
      r_vb_prev <= i_vblank_n;
      r_rd_cell <= w_rd_ok ? r_front[i_rd_row][i_rd_col] : 1'b0;
    end
  end

  assign o_rd_cell    = r_rd_cell;
  assign o_generation = r_gen;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: blinker, wrapping glider, run mode, edge cases, mid-run reset.
module tb_life_engine;

  localparam int G = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblank_n, run, step, clear, wr_en, wr_data;
  logic [4:0]  wr_row, wr_col, rd_row, rd_col;
  logic        rd_cell, busy;
  logic [15:0] generation;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  life_engine #(
    .GRID_SIZE   (G),
    .STEP_FRAMES (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_vblank_n   (vblank_n),
    .i_run        (run),
    .i_step       (step),
    .i_clear      (clear),
    .i_wr_en      (wr_en),
    .i_wr_row     (wr_row),
    .i_wr_col     (wr_col),
    .i_wr_data    (wr_data),
    .i_rd_row     (rd_row),
    .i_rd_col     (rd_col),
    .o_rd_cell    (rd_cell),
    .o_busy       (busy),
    .o_generation (generation)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_cell(input int r, input int c, input logic d);
    wr_row  = 5'(r);
    wr_col  = 5'(c);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic read_cell(input int r, input int c, output logic v);
    rd_row = 5'(r);
    rd_col = 5'(c);
    tick();
    v = rd_cell;
  endtask

  task automatic vb_pulse();
    vblank_n = 1'b0;
    tick();
    vblank_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(busy), 0);
  endtask

  task automatic do_step(input string tag);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (405) tick();
    vb_pulse();
    wait_idle(tag);
  endtask

  task automatic scan_grid(input string tag, input logic [G-1:0][G-1:0] e);
    int   mis  = 0;
    int   live = 0;
    logic v;
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        read_cell(r, c, v);
        if (v !== e[r][c]) mis++;
        if (v === 1'b1) live++;
      end
    end
    check_eq({tag, "_cells_wrong"}, 32'(mis), 0);
    check_eq({tag, "_live"}, 32'(live), 32'($countones(e)));
  endtask

  initial begin
    logic                     v;
    logic [G-1:0][G-1:0]      e;

    rst_n = 1'b0; vblank_n = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
    wr_en = 1'b0; wr_data = 1'b0; wr_row = '0; wr_col = '0; rd_row = '0; rd_col = '0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_gen", 32'(generation), 0);
    check_eq("rst_rd", 32'(rd_cell), 0);
    rst_n = 1'b1;
    e = '0;
    scan_grid("rst_grid", e);
    vblank_n = 1'b1;
    tick();

    // Blinker with ignored writes/clear/step/vblank during COMPUTE
    write_cell(5, 4, 1'b1);
    write_cell(5, 5, 1'b1);
    write_cell(5, 6, 1'b1);
    read_cell(5, 5, v);
    check_eq("wr_latency", 32'(v), 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("step_pending_idle", 32'(busy), 0);
    tick();
    check_eq("step_compute", 32'(busy), 1);
    repeat (48) tick();
    write_cell(0, 0, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (45) tick();
    vb_pulse();
    repeat (310) tick();
    check_eq("vb_in_compute_ignored", 32'(busy), 1);
    read_cell(0, 0, v);
    check_eq("wr_in_compute", 32'(v), 0);
    read_cell(5, 5, v);
    check_eq("clr_in_compute", 32'(v), 1);
    read_cell(4, 5, v);
    check_eq("front_stable", 32'(v), 0);
    vb_pulse();
    wait_idle("blinker_swap");
    check_eq("blinker_gen", 32'(generation), 1);
    repeat (5) tick();
    check_eq("step_in_busy_dropped", 32'(busy), 0);
    e = '0;
    e[4][5] = 1'b1; e[5][5] = 1'b1; e[6][5] = 1'b1;
    scan_grid("blinker", e);

    // Out-of-range write and read
    write_cell(20, 3, 1'b1);
    read_cell(20, 3, v);
    check_eq("oob_read", 32'(v), 0);
    scan_grid("oob_write", e);

    // Clear wins over a same-cycle write
    wr_row = 5'd7; wr_col = 5'd7; wr_data = 1'b1; wr_en = 1'b1; clear = 1'b1;
    tick();
    wr_en = 1'b0; clear = 1'b0;
    e = '0;
    scan_grid("clear_wr", e);

    // Glider crossing both wrap edges, four single steps
    apply_reset();
    write_cell(18, 19, 1'b1);
    write_cell(19, 0, 1'b1);
    write_cell(0, 18, 1'b1);
    write_cell(0, 19, 1'b1);
    write_cell(0, 0, 1'b1);
    for (int i = 0; i < 4; i++) do_step("glider_step");
    check_eq("glider_gen", 32'(generation), 4);
    e = '0;
    e[19][0] = 1'b1; e[0][1] = 1'b1; e[1][19] = 1'b1; e[1][0] = 1'b1; e[1][1] = 1'b1;
    scan_grid("glider", e);

    // Run mode, two frames per generation; swaps land on vblank starts 3, 5, 7
    apply_reset();
    write_cell(10, 10, 1'b1);
    write_cell(10, 11, 1'b1);
    write_cell(11, 10, 1'b1);
    write_cell(11, 11, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vb_pulse();
      repeat (500) tick();
    end
    check_eq("run_gen_6vb", 32'(generation), 2);
    check_eq("run_wait_busy", 32'(busy), 1);
    vb_pulse();
    repeat (3) tick();
    check_eq("run_gen_7vb", 32'(generation), 3);
    run = 1'b0;
    tick();
    check_eq("run_idle", 32'(busy), 0);
    e = '0;
    e[10][10] = 1'b1; e[10][11] = 1'b1; e[11][10] = 1'b1; e[11][11] = 1'b1;
    scan_grid("block", e);

    // Asynchronous reset in the middle of COMPUTE
    read_cell(10, 10, v);
    check_eq("pre_reset_rd", 32'(v), 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (201) tick();
    check_eq("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 32'(busy), 0);
    check_eq("async_rst_gen", 32'(generation), 0);
    check_eq("async_rst_rd", 32'(rd_cell), 0);
    tick();
    rst_n = 1'b1;
    tick();
    e = '0;
    scan_grid("post_reset", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
